// File: rtl/host_link_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the host
// command link responder.
package host_link_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_HALT   = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h05;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/host_rx_shift.sv
// Little-endian 8->32 byte assembler. word_o already includes the byte being
// accepted, so it is the complete field in the cycle done_o is high.
module host_rx_shift (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (en_i) begin
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = {byte_i, word_q[31:8]};
  assign done_o = en_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/host_cmd_responder.sv
// Host command link endpoint: decodes framed byte commands, issues 32-bit
// memory accesses, returns response bytes and owns the core hold line.
module host_cmd_responder
  import host_link_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_hold,
  output logic              busy
);

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]         resp_q, resp_d;
  logic [2:0]          resp_len_q, resp_len_d;
  logic                core_hold_q, core_hold_d;

  logic                rx_en;
  logic                rx_done;
  logic [31:0]         rx_word;

  // Handshake: a byte moves on in_valid & in_ready (and out_valid & out_ready).
  // in_ready and out_valid depend only on state, never on the peer's signal.
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign out_valid = (state_q == ST_RESP);
  assign out_data  = resp_q[7:0];
  assign mem_req   = (state_q == ST_MEM);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign busy      = (state_q != ST_IDLE);

  assign rx_en = in_valid && ((state_q == ST_ADDR) || (state_q == ST_DATA));

  host_rx_shift u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (rx_en),
    .byte_i (in_data),
    .word_o (rx_word),
    .done_o (rx_done)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_d      = resp_q;
    resp_len_d  = resp_len_q;
    core_hold_d = core_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Single-byte commands load their response on the acceptance edge.
          case (in_data)
            OP_WRITE, OP_READ: begin
              mem_we_d = (in_data == OP_WRITE);
              state_d  = ST_ADDR;
            end
            OP_START: begin
              core_hold_d = 1'b0;
              resp_d      = {24'h0, ACK};
              resp_len_d  = 3'd1;
              state_d     = ST_RESP;
            end
            OP_HALT: begin
              core_hold_d = 1'b1;
              resp_d      = {24'h0, ACK};
              resp_len_d  = 3'd1;
              state_d     = ST_RESP;
            end
            OP_STATUS: begin
              resp_d     = {31'h0, core_hold_q};
              resp_len_d = 3'd1;
              state_d    = ST_RESP;
            end
            default: begin
              resp_d     = {24'h0, NACK};
              resp_len_d = 3'd1;
              state_d    = ST_RESP;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          mem_addr_d = {rx_word[ADDR_W-1:2], 2'b00};
          state_d    = mem_we_q ? ST_DATA : ST_MEM;
        end
      end
      ST_DATA: begin
        if (rx_done) begin
          mem_wdata_d = rx_word;
          state_d     = ST_MEM;
        end
      end
      ST_MEM: begin
        if (mem_gnt) begin
          if (mem_we_q) begin
            resp_d     = {24'h0, ACK};
            resp_len_d = 3'd1;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          resp_d     = mem_rdata;
          resp_len_d = 3'd4;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          resp_d     = {8'h00, resp_q[31:8]};
          resp_len_d = resp_len_q - 3'd1;
          if (resp_len_q == 3'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      resp_q      <= 32'h0;
      resp_len_q  <= 3'd0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_q      <= resp_d;
      resp_len_q  <= resp_len_d;
      core_hold_q <= core_hold_d;
    end
  end

endmodule
